gray_to_rgb_colormap: RTL and testbench

Stream expander that converts 4-pixel grayscale beats (32-bit) back into 4-pixel RGB beats (96-bit), applying a selectable colormap: replicate, invert, jet false-colour, or heat. It sits after the stereo matcher, driving disparity or grayscale maps towards the RGB video output path. It honours full AXI-Stream backpressure through a 2-stage stallable pipeline. The colormap mode is frame-synchronous: it changes only at a start-of-frame (tuser) beat.

---
 rtl/gray_rgb_pkg.sv | 32 +++
 rtl/gray_colormap_px.sv | 42 ++++
 rtl/gray_to_rgb_colormap.sv | 98 +++++++++
 tb/tb_gray_to_rgb_colormap.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_rgb_pkg.sv
// Shared constants for the grayscale-to-RGB colormap stream expander:
// colormap codes, pixel widths and the packed RGB byte layout.
package gray_rgb_pkg;

  typedef enum logic [1:0] {
    CMAP_REPLICATE = 2'd0,
    CMAP_INVERT    = 2'd1,
    CMAP_JET       = 2'd2,
    CMAP_HEAT      = 2'd3
  } cmap_e;

  localparam int GRAY_PX_W = 8;
  localparam int RGB_PX_W  = 24;
  localparam int PIXELS    = 4;

  localparam int R_OFS = 16;
  localparam int G_OFS = 0;
  localparam int B_OFS = 8;

  // Places the three colour bytes at their positions within one packed RGB pixel.
  function automatic logic [RGB_PX_W-1:0] packRgb(input logic [7:0] r,
                                                  input logic [7:0] g,
                                                  input logic [7:0] b);
    logic [RGB_PX_W-1:0] px;
    px = '0;
    px[R_OFS +: 8] = r;
    px[G_OFS +: 8] = g;
    px[B_OFS +: 8] = b;
    return px;
  endfunction

endpackage

// File: rtl/gray_colormap_px.sv
// Combinational single-pixel colormap: one 8-bit gray value plus a mode code
// produce one packed 24-bit RGB pixel.
module gray_colormap_px
  import gray_rgb_pkg::*;
(
  input  logic [GRAY_PX_W-1:0] i_gray,
  input  logic [1:0]           i_mode,
  output logic [RGB_PX_W-1:0]  o_rgb
);

  logic [7:0] w_inv;
  logic [7:0] w_frac;
  logic [7:0] w_fracInv;
  logic [7:0] w_dbl;

  assign w_inv     = ~i_gray;
  assign w_frac    = {i_gray[5:0], 2'b00};
  assign w_fracInv = ~w_frac;
  // Dropping the MSB before doubling gives 2g below 128 and 2(g-128) above.
  assign w_dbl     = {i_gray[6:0], 1'b0};

  always_comb begin
    o_rgb = '0;
    case (cmap_e'(i_mode))
      CMAP_REPLICATE: o_rgb = packRgb(i_gray, i_gray, i_gray);
      CMAP_INVERT:    o_rgb = packRgb(w_inv, w_inv, w_inv);
      CMAP_JET: begin
        case (i_gray[7:6])
          2'd0:    o_rgb = packRgb(8'h00, w_frac, 8'hFF);
          2'd1:    o_rgb = packRgb(8'h00, 8'hFF, w_fracInv);
          2'd2:    o_rgb = packRgb(w_frac, 8'hFF, 8'h00);
          default: o_rgb = packRgb(8'hFF, w_fracInv, 8'h00);
        endcase
      end
      default: begin
        if (i_gray[7]) o_rgb = packRgb(8'hFF, w_dbl, 8'h00);
        else           o_rgb = packRgb(w_dbl, 8'h00, 8'h00);
      end
    endcase
  end

endmodule

// File: rtl/gray_to_rgb_colormap.sv
// AXI-Stream expander: 4-pixel gray beats in, 4-pixel RGB beats out, through a
// 2-stage stallable pipeline with a frame-synchronous colormap selection.
module gray_to_rgb_colormap
  import gray_rgb_pkg::*;
#(
  parameter int C_S_AXIS_gray_TDATA_WIDTH = 32,
  parameter int C_M_AXIS_rgb_TDATA_WIDTH  = 96
) (
  input  logic                                 aclk,
  input  logic                                 areset,
  input  logic [1:0]                           cmap_mode,
  input  logic                                 s_axis_gray_tvalid,
  output logic                                 s_axis_gray_tready,
  input  logic [C_S_AXIS_gray_TDATA_WIDTH-1:0] s_axis_gray_tdata,
  input  logic                                 s_axis_gray_tuser,
  input  logic                                 s_axis_gray_tlast,
  output logic                                 m_axis_rgb_tvalid,
  input  logic                                 m_axis_rgb_tready,
  output logic [C_M_AXIS_rgb_TDATA_WIDTH-1:0]  m_axis_rgb_tdata,
  output logic                                 m_axis_rgb_tuser,
  output logic                                 m_axis_rgb_tlast
);

  logic                                 r_v1;
  logic [C_S_AXIS_gray_TDATA_WIDTH-1:0] r_gray1;
  logic                                 r_user1;
  logic                                 r_last1;
  logic [1:0]                           r_mode1;
  logic [1:0]                           r_actMode;

  logic                                 r_v2;
  logic [C_M_AXIS_rgb_TDATA_WIDTH-1:0]  r_rgb2;
  logic                                 r_user2;
  logic                                 r_last2;

  logic                                 w_adv1;
  logic                                 w_ready;
  logic                                 w_accept;
  logic [1:0]                           w_beatMode;
  logic [C_M_AXIS_rgb_TDATA_WIDTH-1:0]  w_rgb;

  assign w_adv1     = !r_v2 || m_axis_rgb_tready;
  assign w_ready    = !areset && (!r_v1 || w_adv1);
  assign w_accept   = s_axis_gray_tvalid && w_ready;
  // A start-of-frame beat uses the freshly requested mode, not the stale one.
  assign w_beatMode = s_axis_gray_tuser ? cmap_mode : r_actMode;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_v1      <= 1'b0;
      r_gray1   <= '0;
      r_user1   <= 1'b0;
      r_last1   <= 1'b0;
      r_mode1   <= 2'd0;
      r_actMode <= 2'd0;
    end else begin
      if (w_ready) r_v1 <= s_axis_gray_tvalid;
      if (w_accept) begin
        r_gray1 <= s_axis_gray_tdata;
        r_user1 <= s_axis_gray_tuser;
        r_last1 <= s_axis_gray_tlast;
        r_mode1 <= w_beatMode;
        if (s_axis_gray_tuser) r_actMode <= cmap_mode;
      end
    end
  end

  for (genvar gi = 0; gi < PIXELS; gi++) begin : g_px
    gray_colormap_px u_px (
      .i_gray (r_gray1[gi*GRAY_PX_W +: GRAY_PX_W]),
      .i_mode (r_mode1),
      .o_rgb  (w_rgb[gi*RGB_PX_W +: RGB_PX_W])
    );
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_v2    <= 1'b0;
      r_rgb2  <= '0;
      r_user2 <= 1'b0;
      r_last2 <= 1'b0;
    end else if (w_adv1) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_rgb2  <= w_rgb;
        r_user2 <= r_user1;
        r_last2 <= r_last1;
      end
    end
  end

  assign s_axis_gray_tready = w_ready;
  assign m_axis_rgb_tvalid  = r_v2;
  assign m_axis_rgb_tdata   = r_rgb2;
  assign m_axis_rgb_tuser   = r_user2;
  assign m_axis_rgb_tlast   = r_last2;

endmodule

// File: tb/tb_gray_to_rgb_colormap.sv
// Scoreboard bench for gray_to_rgb_colormap: the driver queues expected beats as
// inputs are accepted, and an independent monitor pops them on output handshakes.
module tb_gray_to_rgb_colormap;

  logic        clock = 1'b0;
  logic        areset;
  logic [1:0]  cmap_mode;
  logic        s_tvalid;
  logic        s_tready;
  logic [31:0] s_tdata;
  logic        s_tuser;
  logic        s_tlast;
  logic        m_tvalid;
  logic        m_tready;
  logic [95:0] m_tdata;
  logic        m_tuser;
  logic        m_tlast;

  typedef struct packed {
    logic [95:0] data;
    logic        user;
    logic        last;
  } beat_t;

  beat_t       expQ[$];
  beat_t       monBeat;
  int          checks = 0;
  int          passes = 0;
  int          readyCtl = 1;
  logic        prevStall = 1'b0;
  logic [95:0] prevData = '0;

  always #5 clock = ~clock;

  gray_to_rgb_colormap dut (
    .aclk               (clock),
    .areset             (areset),
    .cmap_mode          (cmap_mode),
    .s_axis_gray_tvalid (s_tvalid),
    .s_axis_gray_tready (s_tready),
    .s_axis_gray_tdata  (s_tdata),
    .s_axis_gray_tuser  (s_tuser),
    .s_axis_gray_tlast  (s_tlast),
    .m_axis_rgb_tvalid  (m_tvalid),
    .m_axis_rgb_tready  (m_tready),
    .m_axis_rgb_tdata   (m_tdata),
    .m_axis_rgb_tuser   (m_tuser),
    .m_axis_rgb_tlast   (m_tlast)
  );

  task automatic checkOutput(input string name, input logic [95:0] actual,
                             input logic [95:0] required);
    checks++;
    if (actual === required) passes++;
    else $display("[TB] FAIL %s: actual=%h required=%h", name, actual, required);
  endtask

  // Reference colormap written from the arithmetic definition of each mode.
  function automatic logic [23:0] modelPix(input int g, input int mode);
    int r, gr, b, seg, f;
    r = 0; gr = 0; b = 0;
    seg = g / 64;
    f = (g % 64) * 4;
    case (mode)
      0: begin r = g; gr = g; b = g; end
      1: begin r = 255 - g; gr = 255 - g; b = 255 - g; end
      2: begin
        case (seg)
          0: begin r = 0;   gr = f;       b = 255;     end
          1: begin r = 0;   gr = 255;     b = 255 - f; end
          2: begin r = f;   gr = 255;     b = 0;       end
          default: begin r = 255; gr = 255 - f; b = 0; end
        endcase
      end
      default: begin
        if (g < 128) r = 2 * g;
        else begin r = 255; gr = 2 * (g - 128); end
      end
    endcase
    return {r[7:0], b[7:0], gr[7:0]};
  endfunction

  function automatic logic [95:0] modelBeat(input logic [31:0] data, input int mode);
    logic [95:0] res;
    res = '0;
    for (int i = 0; i < 4; i++) res[24*i +: 24] = modelPix(int'(data[8*i +: 8]), mode);
    return res;
  endfunction

  // Presents one beat (left valid for back-to-back use) and queues its expectation on accept.
  task automatic applyStimulus(input logic [31:0] data, input logic user, input logic last,
                               input logic [1:0] mode, input logic [95:0] expData);
    bit done;
    done = 1'b0;
    s_tdata = data; s_tuser = user; s_tlast = last; cmap_mode = mode; s_tvalid = 1'b1;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clock);
      if (s_tready) begin
        expQ.push_back('{data: expData, user: user, last: last});
        done = 1'b1;
      end
      @(posedge clock); #1;
    end
    if (!done) begin
      checks++;
      $display("[TB] FAIL accept_timeout: actual=no_accept required=accept data=%h", data);
    end
  endtask

  task automatic waitDrain();
    int c;
    c = 0;
    while (expQ.size() != 0 && c < 300) begin
      @(negedge clock);
      c++;
    end
    if (expQ.size() != 0) begin
      checks++;
      $display("[TB] FAIL drain_timeout: actual=%0d pending required=0", expQ.size());
      expQ.delete();
    end
    @(posedge clock); #1;
  endtask

  // Downstream ready: 0 = always ready, 1 = held low, otherwise random.
  initial begin
    m_tready = 1'b0;
    forever begin
      @(posedge clock); #2;
      case (readyCtl)
        0:       m_tready = 1'b1;
        1:       m_tready = 1'b0;
        default: m_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: compares handshaken beats against the queue and checks stall stability.
  always @(negedge clock) begin
    if (areset) prevStall = 1'b0;
    else begin
      if (prevStall) begin
        checkOutput("stall_valid", 96'(m_tvalid), 96'd1);
        checkOutput("stall_data", m_tdata, prevData);
      end
      if (m_tvalid) begin
        if (m_tready) begin
          if (expQ.size() == 0) begin
            checks++;
            $display("[TB] FAIL unexpected_beat: actual=%h required=none", m_tdata);
          end else begin
            monBeat = expQ.pop_front();
            checkOutput("out_data", m_tdata, monBeat.data);
            checkOutput("out_user", 96'(m_tuser), 96'(monBeat.user));
            checkOutput("out_last", 96'(m_tlast), 96'(monBeat.last));
          end
        end
        prevStall = !m_tready;
        prevData  = m_tdata;
      end else prevStall = 1'b0;
    end
  end

  logic [31:0] bpData [8];

  initial begin
    bpData = '{32'h00112233, 32'h4455_6677, 32'h8899AABB, 32'hCCDDEEFF,
               32'h0F1E2D3C, 32'h4B5A6978, 32'h8796A5B4, 32'hC3D2E1F0};
    areset = 1'b1; cmap_mode = 2'd0; s_tvalid = 1'b0; s_tdata = '0;
    s_tuser = 1'b0; s_tlast = 1'b0; readyCtl = 1;

    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("reset_tvalid", 96'(m_tvalid), 96'd0);
    checkOutput("reset_tdata", m_tdata, 96'd0);
    checkOutput("reset_tuser", 96'(m_tuser), 96'd0);
    checkOutput("reset_tlast", 96'(m_tlast), 96'd0);
    checkOutput("reset_tready", 96'(s_tready), 96'd0);
    @(posedge clock); #1;
    areset = 1'b0;
    readyCtl = 0;
    @(posedge clock); #1;

    $display("[TB] mode 0 sanity and latency");
    applyStimulus(32'h80808080, 1'b1, 1'b0, 2'd0, 96'h808080808080808080808080);
    s_tvalid = 1'b0;
    @(negedge clock);
    checkOutput("lat_cycle1_tvalid", 96'(m_tvalid), 96'd0);
    @(negedge clock);
    checkOutput("lat_cycle2_tvalid", 96'(m_tvalid), 96'd1);
    waitDrain();

    $display("[TB] jet, invert, heat");
    applyStimulus(32'hFF804000, 1'b1, 1'b0, 2'd2, 96'hFF00030000FF00FFFF00FF00);
    applyStimulus(32'h10101010, 1'b1, 1'b0, 2'd1, {4{24'hEFEFEF}});
    applyStimulus(32'h90909090, 1'b1, 1'b0, 2'd3, {4{24'hFF0020}});
    s_tvalid = 1'b0;
    waitDrain();

    $display("[TB] frame-synchronous mode switch");
    applyStimulus(32'h40404040, 1'b1, 1'b0, 2'd0, {4{24'h404040}});
    applyStimulus(32'h40404040, 1'b0, 1'b0, 2'd2, {4{24'h404040}});
    applyStimulus(32'h80808080, 1'b0, 1'b1, 2'd2, {4{24'h808080}});
    applyStimulus(32'h00000000, 1'b1, 1'b0, 2'd2, {4{24'h00FF00}});
    applyStimulus(32'h40404040, 1'b0, 1'b0, 2'd0, {4{24'h00FFFF}});
    s_tvalid = 1'b0;
    waitDrain();

    $display("[TB] backpressure");
    readyCtl = 1;
    applyStimulus(bpData[0], 1'b1, 1'b0, 2'd2, modelBeat(bpData[0], 2));
    applyStimulus(bpData[1], 1'b0, 1'b0, 2'd3, modelBeat(bpData[1], 2));
    s_tvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checkOutput("bp_tready_full", 96'(s_tready), 96'd0);
    end
    @(posedge clock); #1;
    readyCtl = 2;
    for (int i = 2; i < 8; i++)
      applyStimulus(bpData[i], 1'b0, (i == 7), 2'(i % 4), modelBeat(bpData[i], 2));
    s_tvalid = 1'b0;
    waitDrain();
    readyCtl = 0;

    $display("[TB] reset mid-stream");
    readyCtl = 1;
    @(posedge clock); #1;
    applyStimulus(32'h11223344, 1'b1, 1'b0, 2'd1, {24'hEEEEEE, 24'hDDDDDD, 24'hCCCCCC, 24'hBBBBBB});
    applyStimulus(32'h55667788, 1'b0, 1'b0, 2'd1, {24'hAAAAAA, 24'h999999, 24'h888888, 24'h777777});
    s_tvalid = 1'b0;
    @(negedge clock);
    checkOutput("pre_reset_tvalid", 96'(m_tvalid), 96'd1);
    #2 areset = 1'b1;
    #1;
    checkOutput("async_reset_tvalid", 96'(m_tvalid), 96'd0);
    checkOutput("async_reset_tready", 96'(s_tready), 96'd0);
    expQ.delete();
    repeat (2) @(posedge clock);
    #1 areset = 1'b0;
    readyCtl = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checkOutput("post_reset_idle", 96'(m_tvalid), 96'd0);
    end
    @(posedge clock); #1;
    applyStimulus(32'h40404040, 1'b0, 1'b0, 2'd2, {4{24'h404040}});
    s_tvalid = 1'b0;
    @(negedge clock);
    checkOutput("post_reset_lat1", 96'(m_tvalid), 96'd0);
    @(negedge clock);
    checkOutput("post_reset_lat2", 96'(m_tvalid), 96'd1);
    waitDrain();

    repeat (3) @(posedge clock);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
